// File: rtl/irq_controller_if.sv
// Bus and CPU-side signal bundle for irq_controller. The CPU/bus side is the
// master; the controller is the slave.
interface irq_controller_if;
  logic [7:0]  bus_addr_ip;
  logic        bus_wr_ip;
  logic [7:0]  bus_wdata_ip;
  logic [7:0]  bus_rdata_op;
  logic        irq_op;
  logic [12:0] irq_vec_op;
  logic        irq_ack_ip;
  logic        irq_ret_ip;

  // Handshake: irq_op is "valid" with irq_vec_op as payload, held stable until
  // the CPU takes it with a one-cycle irq_ack_ip ("ready") or the request is
  // withdrawn; irq_ret_ip is a one-cycle pulse that closes the service window.
  // Writes are single-cycle bus_wr_ip strobes; reads are combinational.
  modport master (
    output bus_addr_ip, bus_wr_ip, bus_wdata_ip, irq_ack_ip, irq_ret_ip,
    input  bus_rdata_op, irq_op, irq_vec_op
  );

  modport slave (
    input  bus_addr_ip, bus_wr_ip, bus_wdata_ip, irq_ack_ip, irq_ret_ip,
    output bus_rdata_op, irq_op, irq_vec_op
  );
endinterface

// File: rtl/irq_controller.sv
// Prioritised 8-source interrupt controller with PEND/MASK/STAT/SWSET registers.
// Optional feature macro: IRQC_VECTORED_EN (per-source vector slots of 2 words).
module irq_controller #(
  parameter int          NUM_SRC  = 8,
  parameter logic [7:0]  REG_BASE = 8'hF0,
  parameter logic [12:0] VEC_BASE = 13'h004
) (
  input  logic               CLK_ip,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq_ip,
  irq_controller_if.slave    bus,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [7:0] SRC_MASK = 8'((16'd1 << NUM_SRC) - 16'd1);

  state_t             state, state_n;
  logic [7:0]         pend, pend_n, mask, mask_n;
  logic [NUM_SRC-1:0] src_d;
  logic [2:0]         id, id_n, sel;
  logic               irq_n;
  logic [12:0]        vec_n;
  logic [7:0]         edge_set, eligible, set_bits, clr_bits;
  logic               wr_pend, wr_mask, wr_swset, ack_take, busy;

  assign state_dbg = state;
  assign busy      = (state != IDLE);

  always_comb begin
    edge_set = '0;
    edge_set[NUM_SRC-1:0] = src_irq_ip & ~src_d;
  end

  assign wr_pend  = bus.bus_wr_ip && (bus.bus_addr_ip == REG_BASE);
  assign wr_mask  = bus.bus_wr_ip && (bus.bus_addr_ip == REG_BASE + 8'd1);
  assign wr_swset = bus.bus_wr_ip && (bus.bus_addr_ip == REG_BASE + 8'd3);
  assign ack_take = (state == REQ) && bus.irq_ack_ip;

  // Set sources are OR-ed after the clear so a same-cycle set beats W1C/ack.
  assign clr_bits = (wr_pend ? bus.bus_wdata_ip : 8'h00) | (ack_take ? (8'd1 << id) : 8'h00);
  assign set_bits = edge_set | (wr_swset ? bus.bus_wdata_ip : 8'h00);
  assign pend_n   = ((pend & ~clr_bits) | set_bits) & SRC_MASK;
  assign mask_n   = wr_mask ? (bus.bus_wdata_ip & SRC_MASK) : mask;
  assign eligible = pend & mask;

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 3'(i);
    end
  end

  always_comb begin
    state_n = state;
    id_n    = id;
    irq_n   = bus.irq_op;
    vec_n   = bus.irq_vec_op;
    case (state)
      IDLE: begin
        if (eligible != 8'h00) begin
          state_n = REQ;
          id_n    = sel;
          irq_n   = 1'b1;
`ifdef IRQC_VECTORED_EN
          vec_n   = VEC_BASE + {9'd0, sel, 1'b0};
`else
          vec_n   = VEC_BASE;
`endif
        end
      end
      REQ: begin
        if (bus.irq_ack_ip) begin
          state_n = SERVICE;
          irq_n   = 1'b0;
        end else if (!pend_n[id] || !mask_n[id]) begin
          // Request withdrawn before the CPU took it; drop without servicing.
          state_n = IDLE;
          irq_n   = 1'b0;
        end
      end
      SERVICE: begin
        if (bus.irq_ret_ip) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_ip) begin
    if (reset) begin
      state          <= IDLE;
      pend           <= 8'h00;
      mask           <= 8'h00;
      src_d          <= '0;
      id             <= 3'd0;
      bus.irq_op     <= 1'b0;
      bus.irq_vec_op <= VEC_BASE;
    end else begin
      state          <= state_n;
      pend           <= pend_n;
      mask           <= mask_n;
      src_d          <= src_irq_ip;
      id             <= id_n;
      bus.irq_op     <= irq_n;
      bus.irq_vec_op <= vec_n;
    end
  end

  always_comb begin
    bus.bus_rdata_op = 8'h00;
    if (bus.bus_addr_ip == REG_BASE)             bus.bus_rdata_op = pend;
    else if (bus.bus_addr_ip == REG_BASE + 8'd1) bus.bus_rdata_op = mask;
    else if (bus.bus_addr_ip == REG_BASE + 8'd2) bus.bus_rdata_op = {busy, 4'b0000, id};
  end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_irq_controller;
  localparam logic [12:0] VEC_BASE = 13'h004;
  localparam logic [7:0]  A_PEND = 8'hF0, A_MASK = 8'hF1, A_STAT = 8'hF2, A_SWSET = 8'hF3;
`ifdef IRQC_VECTORED_EN
  localparam int VEC_STRIDE = 2;
`else
  localparam int VEC_STRIDE = 0;
`endif

  logic       CLK_ip;
  logic       reset;
  logic [7:0] src_irq_ip;
  logic [1:0] state_dbg;

  irq_controller_if bus();

  irq_controller dut (
    .CLK_ip    (CLK_ip),
    .reset     (reset),
    .src_irq_ip(src_irq_ip),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pending/enable sets plus a three-phase controller.
  logic [7:0]  m_pend = 8'h00, m_mask = 8'h00, m_prev = 8'h00;
  int          m_mode = 0;  // 0 idle, 1 requesting, 2 in service
  int          m_id   = 0;
  logic        m_irq  = 1'b0;
  logic [12:0] m_vec  = VEC_BASE;
  logic [13:0] exp_q[$];
  logic        sb_on = 1'b0;

  // clock / reset
  initial CLK_ip = 1'b0;
  always #5 CLK_ip = ~CLK_ip;

  function automatic logic [12:0] exp_vec(input int idx);
    return VEC_BASE + 13'(VEC_STRIDE * idx);
  endfunction

  task automatic model_step();
    logic [7:0] set_b, clr_b, np, nm;
    logic       wr, ack, ret;
    wr  = bus.bus_wr_ip;
    ack = bus.irq_ack_ip;
    ret = bus.irq_ret_ip;
    if (reset) begin
      m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
      m_mode = 0; m_id = 0; m_irq = 1'b0; m_vec = VEC_BASE;
    end else begin
      set_b = src_irq_ip & ~m_prev;
      if (wr && bus.bus_addr_ip == A_SWSET) set_b = set_b | bus.bus_wdata_ip;
      clr_b = (wr && bus.bus_addr_ip == A_PEND) ? bus.bus_wdata_ip : 8'h00;
      if (m_mode == 1 && ack) clr_b[m_id] = 1'b1;
      np = (m_pend & ~clr_b) | set_b;
      nm = (wr && bus.bus_addr_ip == A_MASK) ? bus.bus_wdata_ip : m_mask;
      if (m_mode == 0) begin
        for (int i = 7; i >= 0; i--) begin
          if (m_pend[i] && m_mask[i]) begin
            m_id = i;
            m_mode = 1;
          end
        end
        if (m_mode == 1) begin
          m_irq = 1'b1;
          m_vec = exp_vec(m_id);
        end
      end else if (m_mode == 1) begin
        if (ack) begin
          m_mode = 2; m_irq = 1'b0;
        end else if (!np[m_id] || !nm[m_id]) begin
          m_mode = 0; m_irq = 1'b0;
        end
      end else if (ret) begin
        m_mode = 0;
      end
      m_pend = np;
      m_mask = nm;
      m_prev = src_irq_ip;
    end
    if (sb_on) exp_q.push_back({m_irq, m_vec});
  endtask

  // driver tasks
  task automatic tick();
    model_step();
    @(posedge CLK_ip);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.bus_addr_ip = a;
    #1;
    d = bus.bus_rdata_op;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] v);
    bus.bus_addr_ip  = a;
    bus.bus_wdata_ip = v;
    bus.bus_wr_ip    = 1'b1;
    tick();
    bus.bus_wr_ip    = 1'b0;
    bus.bus_wdata_ip = 8'h00;
  endtask

  task automatic pulse_ack();
    bus.irq_ack_ip = 1'b1;
    tick();
    bus.irq_ack_ip = 1'b0;
  endtask

  task automatic pulse_ret();
    bus.irq_ret_ip = 1'b1;
    tick();
    bus.irq_ret_ip = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_irq_ip = 8'h00;
    bus.bus_addr_ip = 8'h00; bus.bus_wr_ip = 1'b0; bus.bus_wdata_ip = 8'h00;
    bus.irq_ack_ip = 1'b0; bus.irq_ret_ip = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    vectors++;
    if (bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b expected 0", bus.irq_op); end
    vectors++;
    if (bus.irq_vec_op !== VEC_BASE) begin miscompares++; $display("FAIL reset_vec: got %h expected %h", bus.irq_vec_op, VEC_BASE); end
    rd(A_PEND, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_pend: got %h expected 00", d); end
    rd(A_MASK, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_mask: got %h expected 00", d); end
    rd(A_STAT, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL reset_stat: got %h expected 00", d); end
  endtask

  task automatic test_basic_request();
    logic [7:0] d;
    do_reset();
    wr_reg(A_MASK, 8'h05);
    src_irq_ip = 8'h04;
    tick();
    rd(A_PEND, d); vectors++;
    if (d !== 8'h04) begin miscompares++; $display("FAIL basic_pend: got %h expected 04", d); end
    vectors++;
    if (bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL basic_irq_early: got %b expected 0", bus.irq_op); end
    tick();
    vectors++;
    if (bus.irq_op !== 1'b1) begin miscompares++; $display("FAIL basic_irq: got %b expected 1", bus.irq_op); end
    vectors++;
    if (bus.irq_vec_op !== exp_vec(2)) begin miscompares++; $display("FAIL basic_vec: got %h expected %h", bus.irq_vec_op, exp_vec(2)); end
    rd(A_STAT, d); vectors++;
    if (d !== 8'h82) begin miscompares++; $display("FAIL basic_stat: got %h expected 82", d); end
    rd(A_SWSET, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL swset_read: got %h expected 00", d); end
    pulse_ack();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h82 || bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL basic_service: got stat %h irq %b expected 82/0", d, bus.irq_op); end
    pulse_ret();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h02) begin miscompares++; $display("FAIL basic_ret_stat: got %h expected 02", d); end
  endtask

  task automatic test_priority();
    logic [7:0] d;
    do_reset();
    wr_reg(A_MASK, 8'hFF);
    src_irq_ip = 8'h42;
    tick();
    tick();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h81 || bus.irq_vec_op !== exp_vec(1)) begin miscompares++; $display("FAIL prio_first: got stat %h vec %h expected 81/%h", d, bus.irq_vec_op, exp_vec(1)); end
    pulse_ack();
    pulse_ret();
    vectors++;
    if (bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL prio_gap: got %b expected 0", bus.irq_op); end
    tick();
    rd(A_STAT, d); vectors++;
    if (bus.irq_op !== 1'b1 || d !== 8'h86 || bus.irq_vec_op !== exp_vec(6)) begin
      miscompares++; $display("FAIL prio_second: got irq %b stat %h vec %h expected 1/86/%h", bus.irq_op, d, bus.irq_vec_op, exp_vec(6));
    end
    pulse_ack();
    rd(A_PEND, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL prio_pend_clear: got %h expected 00", d); end
    pulse_ret();
  endtask

  task automatic test_mask();
    logic [7:0] d;
    do_reset();
    wr_reg(A_MASK, 8'h00);
    src_irq_ip = 8'h08;
    tick();
    tick();
    tick();
    rd(A_PEND, d); vectors++;
    if (d !== 8'h08 || bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL mask_hold: got pend %h irq %b expected 08/0", d, bus.irq_op); end
    wr_reg(A_MASK, 8'h08);
    tick();
    vectors++;
    if (bus.irq_op !== 1'b1) begin miscompares++; $display("FAIL mask_enable: got %b expected 1", bus.irq_op); end
  endtask

  task automatic test_drop();
    logic [7:0] d;
    do_reset();
    wr_reg(A_MASK, 8'h01);
    src_irq_ip = 8'h01;
    tick();
    tick();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h80 || bus.irq_op !== 1'b1) begin miscompares++; $display("FAIL drop_req: got stat %h irq %b expected 80/1", d, bus.irq_op); end
    wr_reg(A_PEND, 8'h01);
    rd(A_STAT, d); vectors++;
    if (d !== 8'h00 || bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL drop_w1c: got stat %h irq %b expected 00/0", d, bus.irq_op); end
    tick();
    vectors++;
    if (bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL drop_stays: got %b expected 0", bus.irq_op); end
  endtask

  task automatic test_swset();
    logic [7:0] d;
    do_reset();
    wr_reg(A_MASK, 8'h10);
    wr_reg(A_SWSET, 8'h10);
    rd(A_PEND, d); vectors++;
    if (d !== 8'h10) begin miscompares++; $display("FAIL swset_pend: got %h expected 10", d); end
    tick();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h84 || bus.irq_op !== 1'b1) begin miscompares++; $display("FAIL swset_irq: got stat %h irq %b expected 84/1", d, bus.irq_op); end
    pulse_ack();
    pulse_ret();
    src_irq_ip = 8'h10;
    wr_reg(A_PEND, 8'h10);
    rd(A_PEND, d); vectors++;
    if (d !== 8'h10) begin miscompares++; $display("FAIL set_beats_w1c: got %h expected 10", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    tick();
    pulse_ack();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h84) begin miscompares++; $display("FAIL mid_service: got %h expected 84", d); end
    src_irq_ip = 8'h00;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL mid_irq: got %b expected 0", bus.irq_op); end
    rd(A_PEND, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL mid_pend: got %h expected 00", d); end
    rd(A_MASK, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL mid_mask: got %h expected 00", d); end
    rd(A_STAT, d); vectors++;
    if (d !== 8'h00) begin miscompares++; $display("FAIL mid_stat: got %h expected 00", d); end
    pulse_ack();
    pulse_ret();
    rd(A_STAT, d); vectors++;
    if (d !== 8'h00 || bus.irq_op !== 1'b0) begin miscompares++; $display("FAIL idle_pulses: got stat %h irq %b expected 00/0", d, bus.irq_op); end
  endtask

  task automatic test_random();
    logic [13:0] exp;
    logic [7:0]  d, exp_stat;
    do_reset();
    sb_on = 1'b1;
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 2) == 0) src_irq_ip = src_irq_ip ^ (8'd1 << $urandom_range(0, 7));
      bus.bus_wr_ip    = ($urandom_range(0, 4) == 0);
      bus.bus_addr_ip  = A_PEND + 8'($urandom_range(0, 4));
      bus.bus_wdata_ip = 8'($urandom);
      bus.irq_ack_ip   = bus.irq_op ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.irq_ret_ip   = ($urandom_range(0, 4) == 0);
      tick();
      reset = 1'b0;
      bus.bus_wr_ip = 1'b0; bus.irq_ack_ip = 1'b0; bus.irq_ret_ip = 1'b0;
      exp = exp_q.pop_front();
      vectors++;
      if (bus.irq_op !== exp[13]) begin miscompares++; $display("FAIL rnd_irq c=%0d: got %b expected %b", c, bus.irq_op, exp[13]); end
      if (exp[13]) begin
        vectors++;
        if (bus.irq_vec_op !== exp[12:0]) begin miscompares++; $display("FAIL rnd_vec c=%0d: got %h expected %h", c, bus.irq_vec_op, exp[12:0]); end
      end
      rd(A_PEND, d); vectors++;
      if (d !== m_pend) begin miscompares++; $display("FAIL rnd_pend c=%0d: got %h expected %h", c, d, m_pend); end
      rd(A_MASK, d); vectors++;
      if (d !== m_mask) begin miscompares++; $display("FAIL rnd_mask c=%0d: got %h expected %h", c, d, m_mask); end
      exp_stat = {(m_mode != 0), 4'b0000, 3'(m_id)};
      rd(A_STAT, d); vectors++;
      if (d !== exp_stat) begin miscompares++; $display("FAIL rnd_stat c=%0d: got %h expected %h", c, d, exp_stat); end
    end
    sb_on = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    src_irq_ip = 8'h00;
    bus.bus_addr_ip = 8'h00; bus.bus_wr_ip = 1'b0; bus.bus_wdata_ip = 8'h00;
    bus.irq_ack_ip = 1'b0; bus.irq_ret_ip = 1'b0;
    test_reset();
    test_basic_request();
    test_priority();
    test_mask();
    test_drop();
    test_swset();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
